// File: rtl/usb_ft232h_pkg.sv
// Shared types and constants for the FT232H USB core and its TX-side arbiter.
package usb_ft232h_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  localparam logic [2:0] USB_TXDATA_ADDR = 3'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after rr_ptr_i, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [REQ_W-1:0]   rr_ptr_i,
  output logic [REQ_W-1:0]   winner_o,
  output logic               any_req_o
);

  // One extra bit of headroom so the wrap works for non-power-of-2 NUM_REQ.
  function automatic logic [REQ_W-1:0] wrap_idx(input logic [REQ_W-1:0] base,
                                                input int unsigned     off);
    logic [REQ_W:0] sum;
    sum = {1'b0, base} + (REQ_W+1)'(off);
    if (sum >= (REQ_W+1)'(NUM_REQ)) sum = sum - (REQ_W+1)'(NUM_REQ);
    return sum[REQ_W-1:0];
  endfunction

  logic [REQ_W-1:0] idx;

  // Scan farthest-first so the closest requester to rr_ptr_i overwrites last.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = wrap_idx(rr_ptr_i, i);
      if (req_i[idx]) begin
        winner_o  = idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the FT232H core TX FIFO over Avalon-MM.
// Optional mid-packet stall abort: define USB_TX_ARB_TIMEOUT_EN.
module usb_tx_arbiter
  import usb_ft232h_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int REQ_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   pkt_done_o,
  output logic                   timeout_o,
  output logic [2:0]             address_o,
  output logic                   write_o,
  output logic [7:0]             writedata_o,
  input  logic                   waitrequest_i,
  output arb_state_t             dbg_state_o,
  output logic [REQ_W-1:0]       dbg_rr_ptr_o
);

  // Handshake: a requester byte transfers on every cycle where req_valid_i[k] and
  // req_ready_o[k] are both high; ready never depends on valid. Avalon side: a write
  // completes on a cycle with write_o high and waitrequest_i low.

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [REQ_W-1:0]   gidx_q, gidx_d;
  logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               write_q, write_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               pkt_done_q, pkt_done_d;

  logic [REQ_W-1:0]   winner;
  logic               any_req;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               busy, wr_done, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_rr (
    .req_i     (req_valid_i),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == REQ_W'(k)) begin
        sel_valid = req_valid_i[k];
        sel_last  = req_last_i[k];
        sel_data  = req_data_i[8*k +: 8];
      end
    end
  end

  assign busy        = write_q & waitrequest_i;
  assign wr_done     = write_q & ~waitrequest_i;
  assign accept      = (state_q == ARB_XFER) & sel_valid & ~busy;
  assign req_ready_o = ((state_q == ARB_XFER) && !busy) ? grant_q : '0;

`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    pkt_done_d = 1'b0;
`ifdef USB_TX_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          gidx_d          = winner;
          rr_ptr_d        = (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_d         = ARB_XFER;
        end
      end
      ARB_XFER: begin
        // An accept alongside a completing write replaces the byte: back-to-back writes.
        if (accept) begin
          write_d = 1'b1;
          wdata_d = sel_data;
          if (sel_last) state_d = ARB_DRAIN;
        end else if (wr_done) begin
          write_d = 1'b0;
        end
`ifdef USB_TX_ARB_TIMEOUT_EN
        // Only requester starvation counts; core backpressure keeps write_q high.
        if (accept) begin
          stall_d = '0;
        end else if (!write_q) begin
          if (stall_q == STALL_MAX) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            stall_d   = '0;
            state_d   = ARB_IDLE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      ARB_DRAIN: begin
        if (wr_done) begin
          write_d    = 1'b0;
          pkt_done_d = 1'b1;
          grant_d    = '0;
          state_d    = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      write_q    <= 1'b0;
      wdata_q    <= 8'h00;
      pkt_done_q <= 1'b0;
`ifdef USB_TX_ARB_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      pkt_done_q <= pkt_done_d;
`ifdef USB_TX_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

`ifdef USB_TX_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  // No abort logic built; a negative limit is the only way this could ever be 1.
  assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

  assign grant_o      = grant_q;
  assign pkt_done_o   = pkt_done_q;
  assign address_o    = USB_TXDATA_ADDR;
  assign write_o      = write_q;
  assign writedata_o  = wdata_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed self-checking bench for usb_tx_arbiter; the stall-abort case follows USB_TX_ARB_TIMEOUT_EN.
module tb_usb_tx_arbiter;
  import usb_ft232h_pkg::*;

  localparam int NUM_REQ        = 4;
  localparam int REQ_W          = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int W              = NUM_REQ + 8;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic [NUM_REQ-1:0]   req_valid_i = '0;
  logic [8*NUM_REQ-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]   req_last_i = '0;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 pkt_done_o;
  logic                 timeout_o;
  logic [2:0]           address_o;
  logic                 write_o;
  logic [7:0]           writedata_o;
  logic                 waitrequest_i = 1'b0;
  arb_state_t           dbg_state_o;
  logic [REQ_W-1:0]     dbg_rr_ptr_o;

  usb_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .grant_o      (grant_o),
    .pkt_done_o   (pkt_done_o),
    .timeout_o    (timeout_o),
    .address_o    (address_o),
    .write_o      (write_o),
    .writedata_o  (writedata_o),
    .waitrequest_i(waitrequest_i),
    .dbg_state_o  (dbg_state_o),
    .dbg_rr_ptr_o (dbg_rr_ptr_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int pkt_cnt = 0;
  int to_cnt = 0;
  int run_len = 0;
  int last_run = 0;
  int cyc = 0;
  logic [W-1:0]       exp_q[$];
  logic [8:0]         src_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] fire = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completed Avalon write must match the next expected {grant, byte}.
  always @(negedge clk) begin
    fire = req_valid_i & req_ready_o;
    if (!reset_i) begin
      if (write_o && !waitrequest_i) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("write", 32'({grant_o, writedata_o}), 32'(exp_q.pop_front()));
      end
      if (pkt_done_o) pkt_cnt++;
      if (timeout_o) to_cnt++;
      if (write_o) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  // Requester models: each presents the head of its queue, pops on a handshake.
  always @(posedge clk) begin
    logic [8:0] head;
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        head                 = src_q[k][0];
        req_valid_i[k]       = 1'b1;
        req_data_i[8*k +: 8] = head[7:0];
        req_last_i[k]        = head[8];
      end else begin
        req_valid_i[k]       = 1'b0;
        req_data_i[8*k +: 8] = 8'h00;
        req_last_i[k]        = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input int n, input logic [7:0] base, input logic end_last);
    logic [7:0]         b;
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << k;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      src_q[k].push_back({end_last && (i == n - 1), b});
      exp_q.push_back({oh, b});
    end
  endtask

  task automatic flush();
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    waitrequest_i = 1'b0;
    flush();
    repeat (2) step();
    pkt_cnt = 0; to_cnt = 0; run_len = 0; last_run = 0;
    reset_i = 1'b0;
    step();
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && pkt_cnt < n; i++) @(negedge clk);
    @(negedge clk);
    check(tag, 32'(pkt_cnt), 32'(n));
  endtask

  task automatic wait_write(input string tag, input logic [7:0] data, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (write_o && writedata_o == data) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic found;
    int   t0, t1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant",    32'(grant_o),      32'h0);
    check("rst_ready",    32'(req_ready_o),  32'h0);
    check("rst_write",    32'(write_o),      32'h0);
    check("rst_wdata",    32'(writedata_o),  32'h0);
    check("rst_pkt_done", 32'(pkt_done_o),   32'h0);
    check("rst_timeout",  32'(timeout_o),    32'h0);
    check("rst_state",    32'(dbg_state_o),  32'(ARB_IDLE));
    check("rst_rr_ptr",   32'(dbg_rr_ptr_o), 32'h0);
    check("rst_address",  32'(address_o),    32'h0);

    // 1: single requester, three bytes, no backpressure
    do_reset();
    send(1, 3, 8'hA1, 1'b1);
    wait_write("t1_first_write", 8'hA1, 20);
    check("t1_grant", 32'(grant_o), 32'h2);
    wait_pkts("t1_pkts", 1, 30);
    step();
    check("t1_burst_len", 32'(last_run), 32'd3);
    check("t1_grant_idle", 32'(grant_o), 32'h0);
    check("t1_state", 32'(dbg_state_o), 32'(ARB_IDLE));
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: req0 and req2 together, rr_ptr starting at 0
    do_reset();
    send(0, 2, 8'h10, 1'b1);
    send(2, 2, 8'h20, 1'b1);
    wait_pkts("t2_pkts", 2, 40);
    check("t2_rr_ptr", 32'(dbg_rr_ptr_o), 32'd3);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: five cycles of waitrequest on byte 2 of 4
    do_reset();
    send(1, 4, 8'h30, 1'b1);
    wait_write("t3_hit", 8'h31, 20);
    waitrequest_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_write_held", 32'(write_o), 32'd1);
      check("t3_data_held", 32'(writedata_o), 32'h31);
      check("t3_ready_low", 32'(req_ready_o), 32'h0);
      step();
    end
    waitrequest_i = 1'b0;
    wait_pkts("t3_pkts", 1, 30);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: all four requesters, 1-byte packets, 12 packets, fairness
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NUM_REQ; k++)
        send(k, 1, 8'h40 + 8'(4 * r + k), 1'b1);
    wait_pkts("t4_pkts", 12, 120);
    check("t4_rr_ptr", 32'(dbg_rr_ptr_o), 32'd0);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset while a write is outstanding, then a clean packet
    do_reset();
    send(2, 6, 8'h50, 1'b1);
    wait_write("t5_hit", 8'h52, 30);
    reset_i = 1'b1;
    flush();
    step();
    check("t5_write_dropped", 32'(write_o), 32'd0);
    check("t5_grant_cleared", 32'(grant_o), 32'h0);
    check("t5_ready_cleared", 32'(req_ready_o), 32'h0);
    check("t5_state", 32'(dbg_state_o), 32'(ARB_IDLE));
    reset_i = 1'b0;
    pkt_cnt = 0;
    step();
    send(2, 3, 8'h60, 1'b1);
    wait_pkts("t5_pkts", 1, 30);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: requester 3 stalls after one non-last byte
    do_reset();
    send(3, 1, 8'h80, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_o) begin found = 1'b1; break; end
    end
    check("t6_first_write", 32'(found), 32'd1);
    check("t6_grant", 32'(grant_o), 32'h8);
    send(0, 1, 8'h70, 1'b1);
`ifdef USB_TX_ARB_TIMEOUT_EN
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!write_o) begin found = 1'b1; break; end
    end
    check("t6_write_ends", 32'(found), 32'd1);
    t0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (timeout_o) begin found = 1'b1; break; end
    end
    t1 = cyc;
    check("t6_timeout_seen", 32'(found), 32'd1);
    check("t6_timeout_delay", 32'(t1 - t0), 32'd16);
    check("t6_grant_released", 32'(grant_o), 32'h0);
    check("t6_state_idle", 32'(dbg_state_o), 32'(ARB_IDLE));
    check("t6_no_pkt_done", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    check("t6_next_grant", 32'(grant_o), 32'h1);
    check("t6_timeout_pulse", 32'(timeout_o), 32'd0);
    wait_pkts("t6_pkts", 1, 20);
    check("t6_timeout_count", 32'(to_cnt), 32'd1);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`else
    t0 = cyc;
    repeat (40) @(negedge clk);
    t1 = cyc;
    check("t6_wait_cycles", 32'(t1 - t0), 32'd40);
    check("t6_no_timeout", 32'(to_cnt), 32'd0);
    check("t6_grant_held", 32'(grant_o), 32'h8);
    check("t6_state_xfer", 32'(dbg_state_o), 32'(ARB_XFER));
    check("t6_no_pkt_done", 32'(pkt_cnt), 32'd0);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
